// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// funct codes, ALU ops, PC source selects, trap codes and the decode word.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_TRAP = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_LUI  = 4'd7
  } alu_op_t;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_BUS     = 2'd2;

  typedef struct packed {
    logic    s_ext_s;
    alu_op_t alu_op;
    logic    alu_src_imm;
    logic    reg_dst;
    logic    wb_sel;
    logic    is_branch;
    logic    br_ne;
    logic    is_load;
    logic    is_store;
    logic    illegal;
  } ctrl_t;

  function automatic logic is_req_state(input state_t s);
    return (s == ST_IF) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decode into the per-instruction control word.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst = 1'b1;
        case (funct)
          FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: begin
            ctrl.reg_dst = 1'b0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDIU: begin
        ctrl.s_ext_s = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_ADD;
      end
      OP_SLTI: begin
        ctrl.s_ext_s = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_SLT;
      end
      OP_SLTIU: begin
        ctrl.s_ext_s = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_SLTU;
      end
      OP_ANDI: begin
        ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_AND;
      end
      OP_ORI: begin
        ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_OR;
      end
      OP_XORI: begin
        ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_XOR;
      end
      OP_LUI: begin
        ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_LUI;
      end
      OP_LW: begin
        ctrl.s_ext_s = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_ADD;
        ctrl.is_load = 1'b1; ctrl.wb_sel = 1'b1;
      end
      OP_SW: begin
        ctrl.s_ext_s = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_ADD;
        ctrl.is_store = 1'b1;
      end
      // Branches compare rs/rt by subtraction; alu_zero then picks the path.
      OP_BEQ: begin
        ctrl.s_ext_s = 1'b1; ctrl.alu_op = ALU_SUB; ctrl.is_branch = 1'b1;
      end
      OP_BNE: begin
        ctrl.s_ext_s = 1'b1; ctrl.alu_op = ALU_SUB; ctrl.is_branch = 1'b1;
        ctrl.br_ne = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with req/ack memory port and bus timeout trap.
// Optional MC_CTRL_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        s_ext_s,
  output logic        alu_src_imm,
  output logic [3:0]  alu_op,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        wb_sel,
  output logic [1:0]  trap,
  output logic [2:0]  state
`ifdef MC_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]         trap_q, trap_d;
  ctrl_t              ctrl;
  logic               timeout;
  logic               br_taken;
  logic               unused_instr;

  mc_decode u_decode (
    .opcode (instr[31:26]),
    .funct  (instr[5:0]),
    .ctrl   (ctrl)
  );

  assign unused_instr = ^instr[25:6];

  // Counter holds the number of unacked request cycles already spent, so the
  // WAIT_MAX-th unacked cycle is the one that traps; an ack that cycle wins.
  assign timeout  = !mem_ack && (cnt_q == WAIT_W'(WAIT_MAX - 1));
  assign br_taken = ctrl.br_ne ^ alu_zero;

  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: state_d = ST_IF;
      ST_IF: begin
        if (mem_ack) begin
          state_d = ST_ID;
        end else if (timeout) begin
          state_d = ST_TRAP;
          trap_d  = TRAP_BUS;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      ST_ID: begin
        if (ctrl.illegal) begin
          state_d = ST_TRAP;
          trap_d  = TRAP_ILLEGAL;
        end else begin
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        if (ctrl.is_branch)                     state_d = ST_IF;
        else if (ctrl.is_load || ctrl.is_store) state_d = ST_MEM;
        else                                    state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d = ctrl.is_load ? ST_WB : ST_IF;
        end else if (timeout) begin
          state_d = ST_TRAP;
          trap_d  = TRAP_BUS;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      ST_WB:   state_d = ST_IF;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic        retire;

  assign retire = (state_d == ST_IF) &&
                  ((state_q == ST_EX) || (state_q == ST_MEM) || (state_q == ST_WB));

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + 32'd1;
  end

  assign retired = retired_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      trap_q    <= TRAP_NONE;
`ifdef MC_CTRL_RETIRE_CNT_EN
      retired_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trap_q    <= trap_d;
`ifdef MC_CTRL_RETIRE_CNT_EN
      retired_q <= retired_d;
`endif
    end
  end

  // Strobes are a decode of the registered state, so reset kills mem_req at once.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SEQ;
    s_ext_s      = 1'b0;
    alu_src_imm  = 1'b0;
    alu_op       = '0;
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    wb_sel       = 1'b0;
    case (state_q)
      ST_IF: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
        pc_we   = mem_ack;
      end
      ST_ID: s_ext_s = ctrl.s_ext_s;
      ST_EX: begin
        s_ext_s     = ctrl.s_ext_s;
        alu_src_imm = ctrl.alu_src_imm;
        alu_op      = ctrl.alu_op;
        if (ctrl.is_branch && br_taken) begin
          pc_we  = 1'b1;
          pc_src = PC_BRANCH;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = ctrl.is_store;
        s_ext_s      = ctrl.s_ext_s;
      end
      ST_WB: begin
        reg_we  = 1'b1;
        reg_dst = ctrl.reg_dst;
        wb_sel  = ctrl.wb_sel;
        s_ext_s = ctrl.s_ext_s;
      end
      default: ;
    endcase
  end

  assign trap  = trap_q;
  assign state = state_q;

  logic unused_req_state;
  assign unused_req_state = is_req_state(state_q);

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction phase scripts built from
// the instruction class, compared cycle by cycle against all DUT outputs.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int K_R = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_ILL = 6;
  localparam int P_IF = 1, P_ID = 2, P_EX = 3, P_MEM = 4, P_WB = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0]  pc_src;
  logic        s_ext_s, alu_src_imm;
  logic [3:0]  alu_op;
  logic        reg_we, reg_dst, wb_sel;
  logic [1:0]  trap;
  logic [2:0]  state;
`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [31:0] retired;
  logic [31:0] exp_retired = '0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.WAIT_MAX(255), .WAIT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .alu_zero     (alu_zero),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .s_ext_s      (s_ext_s),
    .alu_src_imm  (alu_src_imm),
    .alu_op       (alu_op),
    .reg_we       (reg_we),
    .reg_dst      (reg_dst),
    .wb_sel       (wb_sel),
    .trap         (trap),
    .state        (state)
`ifdef MC_CTRL_RETIRE_CNT_EN
    ,
    .retired      (retired)
`endif
  );

  logic [21:0] obs;
  assign obs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, s_ext_s,
                alu_src_imm, alu_op, reg_we, reg_dst, wb_sel, trap, state};

  function automatic logic [21:0] mk(input logic req, input logic we, input logic asel,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic sx, input logic asrc, input logic [3:0] aop,
                                     input logic rw, input logic rd, input logic wbs,
                                     input logic [1:0] tr, input logic [2:0] st);
    return {req, we, asel, irw, pcw, pcs, sx, asrc, aop, rw, rd, wbs, tr, st};
  endfunction

  // Instruction-set table: class, extender mode and ALU function.
  function automatic void classify(input logic [31:0] ins, output int kind,
                                   output logic sx, output logic [3:0] aop);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    kind = K_ILL; sx = 1'b0; aop = 4'd0;
    case (op)
      6'h00: begin
        kind = K_R;
        case (fn)
          6'h21: aop = ALU_ADD;
          6'h23: aop = ALU_SUB;
          6'h24: aop = ALU_AND;
          6'h25: aop = ALU_OR;
          6'h2A: aop = ALU_SLT;
          default: kind = K_ILL;
        endcase
      end
      6'h09: begin kind = K_IALU; sx = 1'b1; aop = ALU_ADD;  end
      6'h0A: begin kind = K_IALU; sx = 1'b1; aop = ALU_SLT;  end
      6'h0B: begin kind = K_IALU; sx = 1'b1; aop = ALU_SLTU; end
      6'h0C: begin kind = K_IALU; aop = ALU_AND; end
      6'h0D: begin kind = K_IALU; aop = ALU_OR;  end
      6'h0E: begin kind = K_IALU; aop = ALU_XOR; end
      6'h0F: begin kind = K_IALU; aop = ALU_LUI; end
      6'h23: begin kind = K_LW;  sx = 1'b1; aop = ALU_ADD; end
      6'h2B: begin kind = K_SW;  sx = 1'b1; aop = ALU_ADD; end
      6'h04: begin kind = K_BEQ; sx = 1'b1; aop = ALU_SUB; end
      6'h05: begin kind = K_BNE; sx = 1'b1; aop = ALU_SUB; end
      default: kind = K_ILL;
    endcase
    if (kind == K_ILL) aop = 4'd0;
  endfunction

  function automatic logic [31:0] rand_legal(input int idx, input logic [31:0] r);
    logic [5:0] op, fn;
    op = 6'h00; fn = 6'h00;
    case (idx)
      0: fn = 6'h21;  1: fn = 6'h23;  2: fn = 6'h24;  3: fn = 6'h25;  4: fn = 6'h2A;
      5: op = 6'h09;  6: op = 6'h0A;  7: op = 6'h0B;  8: op = 6'h0C;  9: op = 6'h0D;
      10: op = 6'h0E; 11: op = 6'h0F; 12: op = 6'h23; 13: op = 6'h2B; 14: op = 6'h04;
      default: op = 6'h05;
    endcase
    if (op == 6'h00) return {6'h00, r[25:6], fn};
    return {op, r[25:0]};
  endfunction

  // Call at a negedge; leaves the DUT in its first IF cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ack = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
`ifdef MC_CTRL_RETIRE_CNT_EN
    exp_retired = '0;
`endif
  endtask

  // Runs one legal instruction from its first IF cycle to the next IF.
  task automatic run_instr(input string tag, input logic [31:0] ins, input logic az,
                           input int if_wait, input int mem_wait);
    int kind, ph[$], k;
    logic sx, imm, taken, last;
    logic [3:0] aop;
    logic [21:0] e;
    classify(ins, kind, sx, aop);
    for (int w = 0; w <= if_wait; w++) ph.push_back(P_IF);
    ph.push_back(P_ID);
    ph.push_back(P_EX);
    if (kind == K_LW || kind == K_SW)
      for (int w = 0; w <= mem_wait; w++) ph.push_back(P_MEM);
    if (kind != K_SW && kind != K_BEQ && kind != K_BNE) ph.push_back(P_WB);
    imm   = (kind == K_IALU) || (kind == K_LW) || (kind == K_SW);
    taken = (kind == K_BEQ && az) || (kind == K_BNE && !az);
    for (k = 0; k < ph.size(); k++) begin
      last = (k == ph.size() - 1) || (ph[k+1] != ph[k]);
      instr    = (ph[k] == P_IF) ? $urandom : ins;
      mem_ack  = (ph[k] == P_IF || ph[k] == P_MEM) ? last : 1'($urandom_range(0, 1));
      alu_zero = (ph[k] == P_EX) ? az : 1'($urandom_range(0, 1));
      #1;
      case (ph[k])
        P_IF:  e = mk(1, 0, 0, mem_ack, mem_ack, PC_SEQ, 0, 0, 4'd0, 0, 0, 0, TRAP_NONE, ST_IF);
        P_ID:  e = mk(0, 0, 0, 0, 0, PC_SEQ, sx, 0, 4'd0, 0, 0, 0, TRAP_NONE, ST_ID);
        P_EX:  e = mk(0, 0, 0, 0, taken, taken ? PC_BRANCH : PC_SEQ, sx, imm, aop,
                      0, 0, 0, TRAP_NONE, ST_EX);
        P_MEM: e = mk(1, kind == K_SW, 1, 0, 0, PC_SEQ, sx, 0, 4'd0, 0, 0, 0, TRAP_NONE, ST_MEM);
        default: e = mk(0, 0, 0, 0, 0, PC_SEQ, sx, 0, 4'd0, 1, kind == K_R, kind == K_LW,
                        TRAP_NONE, ST_WB);
      endcase
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s instr=%h cycle=%0d phase=%0d got=%h expected=%h",
                 tag, ins, k, ph[k], obs, e);
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
`ifdef MC_CTRL_RETIRE_CNT_EN
    exp_retired++;
    checks++;
    if (retired !== exp_retired) begin
      failures++;
      $display("FAIL %s_retired got=%0d expected=%0d", tag, retired, exp_retired);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (obs !== mk(0,0,0,0,0,0,0,0,4'd0,0,0,0,TRAP_NONE,ST_IDLE)) begin
      failures++; $display("FAIL reset_state got=%h expected=%h", obs, 22'(ST_IDLE));
    end
`ifdef MC_CTRL_RETIRE_CNT_EN
    checks++;
    if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d expected=0", retired); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== mk(0,0,0,0,0,0,0,0,4'd0,0,0,0,TRAP_NONE,ST_IDLE)) begin
      failures++; $display("FAIL idle_after_release got=%h", obs);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_instr("addiu", 32'h2401FFFF, 1'b0, 0, 0);
    run_instr("ori",   32'h3421FFFF, 1'b0, 0, 0);
    run_instr("lw_wait3", 32'h8C220004, 1'b0, 0, 3);
    run_instr("beq_taken", 32'h1022FFFE, 1'b1, 0, 0);
    run_instr("beq_not_taken", 32'h1022FFFE, 1'b0, 0, 0);
    run_instr("bne_taken", 32'h1422FFFE, 1'b0, 1, 0);
    run_instr("sw", 32'hAC220008, 1'b0, 2, 1);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 80; n++) begin
      ins = rand_legal($urandom_range(0, 15), $urandom);
      run_instr("random", ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins;
    int kind;
    logic sx;
    logic [3:0] aop;
    for (int n = 0; n < 6; n++) begin
      ins = {6'h3F, 26'($urandom)};
      if (n > 0)
        for (int t = 0; t < 100; t++) begin
          ins = $urandom;
          if (n[0]) ins[31:26] = 6'h00;
          classify(ins, kind, sx, aop);
          if (kind == K_ILL) break;
        end
      do_reset();
      instr = $urandom; mem_ack = 1'b1;
      @(negedge clk);
      instr = ins; mem_ack = 1'b0;
      #1;
      checks++;
      if (obs !== mk(0,0,0,0,0,0,0,0,4'd0,0,0,0,TRAP_NONE,ST_ID)) begin
        failures++; $display("FAIL illegal_id instr=%h got=%h", ins, obs);
      end
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
        mem_ack = 1'($urandom_range(0, 1)); alu_zero = 1'($urandom_range(0, 1)); instr = $urandom;
        #1;
        checks++;
        if (obs !== mk(0,0,0,0,0,0,0,0,4'd0,0,0,0,TRAP_ILLEGAL,ST_TRAP)) begin
          failures++; $display("FAIL illegal_trap instr=%h got=%h expected=%h", ins, obs,
                               mk(0,0,0,0,0,0,0,0,4'd0,0,0,0,TRAP_ILLEGAL,ST_TRAP));
        end
        @(negedge clk);
      end
`ifdef MC_CTRL_RETIRE_CNT_EN
      checks++;
      if (retired !== 32'd0) begin failures++; $display("FAIL trap_retired got=%0d expected=0", retired); end
`endif
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== mk(0,0,0,0,0,0,0,0,4'd0,0,0,0,TRAP_NONE,ST_IDLE)) begin
        failures++; $display("FAIL trap_reset got=%h", obs);
      end
      #1 rst_n = 1'b1;
      mem_ack = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 255; c++) begin
      mem_ack = 1'b0; instr = $urandom;
      #1;
      checks++;
      if (obs !== mk(1,0,0,0,0,PC_SEQ,0,0,4'd0,0,0,0,TRAP_NONE,ST_IF)) begin
        failures++; $display("FAIL if_wait cycle=%0d got=%h", c, obs);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs !== mk(0,0,0,0,0,0,0,0,4'd0,0,0,0,TRAP_BUS,ST_TRAP)) begin
        failures++; $display("FAIL if_timeout got=%h expected=%h", obs,
                             mk(0,0,0,0,0,0,0,0,4'd0,0,0,0,TRAP_BUS,ST_TRAP));
      end
      @(negedge clk);
    end
    // Store stalls in MEM until the bus gives up.
    do_reset();
    instr = $urandom; mem_ack = 1'b1;
    @(negedge clk);
    instr = 32'hAC220008; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 255; c++) begin
      #1;
      checks++;
      if (obs !== mk(1,1,1,0,0,PC_SEQ,1,0,4'd0,0,0,0,TRAP_NONE,ST_MEM)) begin
        failures++; $display("FAIL mem_wait cycle=%0d got=%h", c, obs);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (obs !== mk(0,0,0,0,0,0,0,0,4'd0,0,0,0,TRAP_BUS,ST_TRAP)) begin
      failures++; $display("FAIL mem_timeout got=%h", obs);
    end
    @(negedge clk);
    // Ack on the final permitted cycle beats the timeout.
    do_reset();
    run_instr("ack_wins_if", 32'h2401FFFF, 1'b0, 254, 0);
    run_instr("ack_wins_mem", 32'h8C220004, 1'b0, 0, 254);
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int c = 0; c < 10; c++) @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || state !== 3'(ST_IF)) begin
      failures++; $display("FAIL mid_wait_req got req=%b state=%0d expected req=1 state=%0d", mem_req, state, ST_IF);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== mk(0,0,0,0,0,0,0,0,4'd0,0,0,0,TRAP_NONE,ST_IDLE)) begin
      failures++; $display("FAIL mid_wait_reset got=%h", obs);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
`ifdef MC_CTRL_RETIRE_CNT_EN
    exp_retired = '0;
`endif
    run_instr("after_reset", 32'h00221821, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS core.
- Sequences fetch/decode/execute/memory/writeback and drives all datapath selects, including `s_ext_s` for the 16-bit immediate extender, ALU source/op, PC, IR, register-file and memory strobes.
- Sits between the IR/ALU datapath and a variable-latency memory port with req/ack handshake.

Parameters:
- WAIT_MAX, 255, max cycles `mem_req` may wait for `mem_ack` before bus-error trap.
- WAIT_W, 8, width of wait counter; must hold WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  current IR contents; valid from ID onward.
- alu_zero  in  1  ALU result == 0.
- mem_ack  in  1  memory completes access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr_sel  out  1  0=PC, 1=ALU result.
- ir_we  out  1  load IR.
- pc_we  out  1  load PC.
- pc_src  out  2  0=PC+4, 1=branch target, others reserved.
- s_ext_s  out  1  1=sign-extend imm16, 0=zero-extend.
- alu_src_imm  out  1  ALU B = extended immediate.
- alu_op  out  4  ALU function code (package encoding).
- reg_we  out  1  register-file write.
- reg_dst  out  1  0=rt, 1=rd.
- wb_sel  out  1  0=ALU, 1=memory data.
- trap  out  2  0=none, 1=illegal instr, 2=bus timeout; sticky.
- state  out  3  current state (debug).

Behaviour:
- Interface: one clock `clk`; `rst_n` asynchronous, active-low. Reset forces IDLE, wait counter 0, trap 0.
- Outputs are decoded from registered state plus `instr`. All outputs are 0 in IDLE and TRAP.
- States: IDLE, IF, ID, EX, MEM, WB, TRAP.
- IDLE: unconditional transition to IF next cycle.
- IF: mem_req=1, mem_addr_sel=0, mem_we=0.
  - Hold until mem_ack.
  - On the ack cycle: ir_we=1, pc_we=1, pc_src=0, then go to ID.
- ID: decode only; no strobes.
  - Unsupported opcode/funct -> TRAP with trap=1.
  - Otherwise -> EX.
- Supported instructions:
  - R-type funct addu/subu/and/or/slt.
  - addiu, slti, sltiu, andi, ori, xori, lui, lw, sw, beq, bne.
- s_ext_s:
  - 1 for addiu/slti/sltiu/lw/sw/beq/bne.
  - 0 for andi/ori/xori/lui and R-type.
  - Stable from ID through the last state of the instruction.
- EX: alu_src_imm=1 for every I-type except beq/bne; alu_op per decode.
  - beq taken (alu_zero=1) or bne taken (alu_zero=0): pc_we=1, pc_src=1 -> IF.
  - Branch not taken -> IF.
  - lw/sw -> MEM.
  - All other instructions -> WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(sw); hold until ack.
  - lw -> WB.
  - sw -> IF.
- WB: reg_we=1 for exactly one cycle.
  - reg_dst=1 for R-type, else 0.
  - wb_sel=1 for lw.
  - Then -> IF.
- Cycles per instruction, with zero-wait memory (ack in the first request cycle):
  - branch 3, ALU 4, sw 4, lw 5.
  - Each wait cycle adds 1.
- Handshake:
  - mem_req and its attributes stay constant until the ack cycle.
  - mem_ack outside IF/MEM is ignored.
  - Wait counter clears on entry to IF/MEM and increments each unacked request cycle.
  - If the counter reaches WAIT_MAX without ack: next state TRAP, trap=2, mem_req dropped.
- TRAP: terminal; exited only by reset.
- Reset mid-operation: immediate return to IDLE; any outstanding request is abandoned and mem_req deasserts asynchronously.
- Simultaneous timeout and ack in the same cycle: ack wins.

Optional Feature:
- MC_CTRL_RETIRE_CNT_EN defined:
  - Adds output `retired` (32 bits), reset 0.
  - Increments by 1 on each transition into IF from EX, MEM or WB.
  - Wraps 0xFFFFFFFF -> 0.
  - Never counts in TRAP.
- MC_CTRL_RETIRE_CNT_EN undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package `mc_ctrl_pkg`:
  - state encoding.
  - opcode and funct constants.
  - alu_op encodings.
  - pc_src encodings.
  - trap codes.
- Sub-module `mc_decode`: combinational decode of opcode/funct into a control word (s_ext_s, alu_op, alu_src_imm, reg_dst, wb_sel, is_branch/is_load/is_store, illegal).
- `mc_ctrl` holds the FSM, wait counter and the optional retire counter.

Test Plan:
- Reset release, zero-wait memory, instr=addiu 0x2401FFFF -> IDLE, IF, ID, EX, WB; s_ext_s=1, alu_src_imm=1, reg_we high one cycle, reg_dst=0.
- instr=ori 0x3421FFFF -> s_ext_s=0 during ID..WB, 4 cycles from IF to next IF.
- lw 0x8C220004 with mem_ack delayed 3 cycles in MEM -> mem_req/mem_addr_sel=1 held 4 cycles, then WB with wb_sel=1; retired increments by 1 if enabled.
- beq 0x1022FFFE with alu_zero=1 -> EX asserts pc_we=1, pc_src=1, s_ext_s=1; with alu_zero=0 -> no pc_we in EX; both return to IF after 3 cycles.
- Opcode 0x3F -> TRAP with trap=1; all strobes 0 forever; rst_n pulse low returns to IDLE with trap=0.
- mem_ack never asserted in IF, WAIT_MAX=255 -> trap=2 after 255 request cycles, mem_req low; asserting rst_n low mid-wait instead -> mem_req drops immediately.
